// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and single-outstanding instruction fetch front end feeding IF/ID
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic        en_reg_out
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, KILL} state_t;
    state_t state;
    logic [31:0] pc;
    logic [31:0] target;
    assign target = redirect_pc & ~32'h3;
    assign imem_req = state == FETCH;
    assign imem_addr = pc;
    assign en_reg_out = valid_out & ~stall_in & ~redirect_valid;
    // fetch sequencing: a redirect always wins, squashed responses are drained in KILL
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            state <= FETCH;
            valid_out <= 1'b0;
            instr_out <= NOP_INSTR;
            pc_out <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    state <= redirect_valid ? KILL : WAIT;
                    if (redirect_valid) pc <= target;
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc <= target;
                        state <= imem_rvalid ? FETCH : KILL;
                    end else if (imem_rvalid) begin
                        instr_out <= imem_rdata;
                        pc_out <= pc;
                        valid_out <= 1'b1;
                        pc <= pc + PC_STEP;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid || !stall_in) begin
                        valid_out <= 1'b0;
                        instr_out <= NOP_INSTR;
                        state <= FETCH;
                        if (redirect_valid) pc <= target;
                    end
                end
                KILL: begin
                    if (redirect_valid) pc <= target;
                    if (imem_rvalid) state <= FETCH;
                end
            endcase
        end
    end
endmodule
